mem_stage: RTL and testbench

Pipeline MEM stage of the five-stage CPU. It consumes the EX/MEM register outputs, performs the data-memory load or store over a req/ack bus, and stalls the pipeline while the access is outstanding. It also holds the MEM/WB register that feeds write-back, and inserts bubbles into it while stalled.

---
 rtl/mem_pkg.sv | 21 ++
 rtl/mem_stage_memwb_reg.sv | 46 ++++
 rtl/mem_stage.sv | 153 +++++++++++++++
 tb/tb_mem_stage.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM pipeline stage.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam int unsigned WB_REGWRITE     = 1;
    localparam int unsigned WB_MEMTOREG     = 0;
    localparam int unsigned M_READ          = 1;
    localparam int unsigned M_WRITE         = 0;

    localparam int unsigned TIMEOUT_CYC_DEF = 255;
    localparam int unsigned CNT_W           = 8;
    localparam int unsigned XLEN            = 32;
    localparam int unsigned RD_W            = 5;
    localparam int unsigned WB_W            = 2;

endpackage

// File: rtl/mem_stage_memwb_reg.sv
// MEM/WB pipeline register: full load, or bubble (control and rd cleared, data held).
module memwb_reg
    import mem_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_load,
    input  logic            i_bubble,
    input  logic [WB_W-1:0] i_wb,
    input  logic [XLEN-1:0] i_rdata,
    input  logic [XLEN-1:0] i_alu,
    input  logic [RD_W-1:0] i_rd,
    output logic [WB_W-1:0] o_wb,
    output logic [XLEN-1:0] o_rdata,
    output logic [XLEN-1:0] o_alu,
    output logic [RD_W-1:0] o_rd
);

    logic [WB_W-1:0] r_wb;
    logic [XLEN-1:0] r_rdata;
    logic [XLEN-1:0] r_alu;
    logic [RD_W-1:0] r_rd;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wb    <= '0;
            r_rdata <= '0;
            r_alu   <= '0;
            r_rd    <= '0;
        end else if (i_load) begin
            r_wb    <= i_wb;
            r_rdata <= i_rdata;
            r_alu   <= i_alu;
            r_rd    <= i_rd;
        end else if (i_bubble) begin
            r_wb    <= '0;
            r_rd    <= '0;
        end
    end

    assign o_wb    = r_wb;
    assign o_rdata = r_rdata;
    assign o_alu   = r_alu;
    assign o_rd    = r_rd;

endmodule

// File: rtl/mem_stage.sv
// MEM stage: req/ack data-memory access with stall, timeout abort and MEM/WB register.
module mem_stage
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic [WB_W-1:0] WB_i,
    input  logic [1:0]      M_i,
    input  logic [XLEN-1:0] addr_i,
    input  logic [XLEN-1:0] data_i,
    input  logic [RD_W-1:0] rd_i,
    output logic            stall_o,
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [XLEN-1:0] mem_wdata_o,
    input  logic            mem_ack_i,
    input  logic [XLEN-1:0] mem_rdata_i,
    output logic            err_o,
    output logic [WB_W-1:0] WB_o,
    output logic [XLEN-1:0] rdata_o,
    output logic [XLEN-1:0] alu_o,
    output logic [RD_W-1:0] rd_o
);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [WB_W-1:0] r_wb;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_data;
    logic [RD_W-1:0] r_rd;
    logic            r_we;
    logic [CNT_W-1:0] r_cnt;
    logic            r_err;

    logic            w_mem_op;
    logic            w_access;
    logic            w_load;
    logic            w_bubble;
    logic            w_capture;
    logic            w_cnt_inc;
    logic            w_err_set;
    logic [WB_W-1:0] w_wb_in;
    logic [XLEN-1:0] w_alu_in;
    logic [XLEN-1:0] w_rdata_in;
    logic [RD_W-1:0] w_rd_in;

    assign w_mem_op = M_i[M_READ] | M_i[M_WRITE];
    assign w_access = (r_state == ACCESS);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next state plus MEM/WB and bookkeeping controls
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_bubble    = 1'b0;
        w_capture   = 1'b0;
        w_cnt_inc   = 1'b0;
        w_err_set   = 1'b0;
        w_wb_in     = WB_i;
        w_alu_in    = addr_i;
        w_rdata_in  = '0;
        w_rd_in     = rd_i;
        case (r_state)
            IDLE: begin
                if (w_mem_op) begin
                    w_capture   = 1'b1;
                    w_bubble    = 1'b1;
                    w_state_nxt = ACCESS;
                end else begin
                    w_load = 1'b1;
                end
            end
            ACCESS: begin
                if (mem_ack_i) begin
                    w_load      = 1'b1;
                    w_wb_in     = r_wb;
                    w_alu_in    = r_addr;
                    w_rd_in     = r_rd;
                    w_rdata_in  = r_we ? '0 : mem_rdata_i;
                    w_state_nxt = DONE;
                end else if (r_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                    w_bubble    = 1'b1;
                    w_err_set   = 1'b1;
                    w_state_nxt = DONE;
                end else begin
                    w_bubble  = 1'b1;
                    w_cnt_inc = 1'b1;
                end
            end
            DONE: begin
                w_bubble    = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Captured instruction, timeout counter and sticky error
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_wb   <= '0;
            r_addr <= '0;
            r_data <= '0;
            r_rd   <= '0;
            r_we   <= 1'b0;
            r_cnt  <= '0;
            r_err  <= 1'b0;
        end else begin
            if (w_capture) begin
                r_wb   <= WB_i;
                r_addr <= addr_i;
                r_data <= data_i;
                r_rd   <= rd_i;
                r_we   <= M_i[M_WRITE];
                r_cnt  <= '0;
            end else if (w_cnt_inc) begin
                r_cnt  <= r_cnt + CNT_W'(1);
            end
            if (w_err_set) r_err <= 1'b1;
        end
    end

    // Stall is combinational; gating with reset makes it drop immediately on reset
    assign stall_o     = rst_n_i & (w_access | ((r_state == IDLE) & w_mem_op));
    assign mem_req_o   = w_access;
    assign mem_we_o    = w_access & r_we;
    assign mem_addr_o  = w_access ? r_addr : '0;
    assign mem_wdata_o = w_access ? r_data : '0;
    assign err_o       = r_err;

    memwb_reg u_memwb (
        .i_clk    (clk_i),
        .i_rst_n  (rst_n_i),
        .i_load   (w_load),
        .i_bubble (w_bubble),
        .i_wb     (w_wb_in),
        .i_rdata  (w_rdata_in),
        .i_alu    (w_alu_in),
        .i_rd     (w_rd_in),
        .o_wb     (WB_o),
        .o_rdata  (rdata_o),
        .o_alu    (alu_o),
        .o_rd     (rd_o)
    );

endmodule

// File: tb/tb_mem_stage.sv
// Randomized and directed bench for mem_stage against an instruction-level latency model.
module tb_mem_stage;

    localparam int T = 4;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic [1:0]  WB_i;
    logic [1:0]  M_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic [4:0]  rd_i;
    logic        stall_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic        err_o;
    logic [1:0]  WB_o;
    logic [31:0] rdata_o;
    logic [31:0] alu_o;
    logic [4:0]  rd_o;

    int checks = 0;
    int errors = 0;

    // Model of architectural MEM/WB data fields and error flag
    logic [31:0] m_alu;
    logic [31:0] m_rdata;
    logic        m_err;
    int          low_run;
    bit          have_req;
    bit          req_prev;

    mem_stage #(.TIMEOUT_CYC(T)) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .WB_i        (WB_i),
        .M_i         (M_i),
        .addr_i      (addr_i),
        .data_i      (data_i),
        .rd_i        (rd_i),
        .stall_o     (stall_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i),
        .err_o       (err_o),
        .WB_o        (WB_o),
        .rdata_o     (rdata_o),
        .alu_o       (alu_o),
        .rd_o        (rd_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stall"}, 32'(stall_o), 32'd0);
        chk({tag, "_req"},   32'(mem_req_o), 32'd0);
        chk({tag, "_we"},    32'(mem_we_o), 32'd0);
        chk({tag, "_addr"},  mem_addr_o, 32'd0);
        chk({tag, "_wdata"}, mem_wdata_o, 32'd0);
        chk({tag, "_err"},   32'(err_o), 32'd0);
        chk({tag, "_wb"},    32'(WB_o), 32'd0);
        chk({tag, "_rdata"}, rdata_o, 32'd0);
        chk({tag, "_alu"},   alu_o, 32'd0);
        chk({tag, "_rd"},    32'(rd_o), 32'd0);
    endtask

    // One instruction; lat = cycles from req rise to ack, lat >= T means never acked
    task automatic run_instr(input logic [1:0] wb, input logic [1:0] m, input logic [31:0] addr,
                             input logic [31:0] data, input logic [4:0] rd, input int lat,
                             input logic [31:0] rdv);
        bit          memop, we, tmo, done;
        int          cyc, stall_cnt, req_cnt, nb, nb_exp;
        logic [1:0]  e_wb;
        logic [31:0] e_alu, e_rdata;
        logic [4:0]  e_rd;
        memop = (m != 2'b00);
        we    = m[0];
        tmo   = memop && (lat >= T);
        if (!tmo) begin
            e_wb = wb; e_alu = addr; e_rd = rd;
            e_rdata = (memop && !we) ? rdv : 32'h0;
        end else begin
            e_wb = 2'b00; e_alu = m_alu; e_rd = 5'd0; e_rdata = m_rdata;
        end
        nb_exp = (e_wb != 2'b00 || e_rd != 5'd0) ? 1 : 0;

        WB_i = wb; M_i = m; addr_i = addr; data_i = data; rd_i = rd; mem_ack_i = 1'b0;
        #1;
        cyc = 0; stall_cnt = 0; req_cnt = 0; nb = 0; done = 0;
        while (!done) begin
            if (cyc >= 40) begin
                checks++; errors++;
                $error("FAIL budget observed=%0d cycles expected<40", cyc);
                break;
            end
            if (stall_o) stall_cnt++;
            if (mem_req_o) begin
                if (!req_prev && have_req) chk("req_gap", 32'(low_run >= 2), 32'd1);
                chk("bus_addr",  mem_addr_o, addr);
                chk("bus_we",    32'(mem_we_o), 32'(we));
                chk("bus_wdata", mem_wdata_o, data);
                mem_ack_i   = (req_cnt == lat);
                mem_rdata_i = mem_ack_i ? rdv : $urandom;
                req_cnt++;
                low_run  = 0;
                have_req = 1;
            end else begin
                chk("bus_idle", 32'(mem_we_o) | mem_addr_o | mem_wdata_o, 32'd0);
                mem_ack_i   = 1'($urandom_range(0, 1));
                mem_rdata_i = $urandom;
                low_run++;
            end
            req_prev = mem_req_o;
            if (cyc > 0 && (WB_o != 2'b00 || rd_o != 5'd0)) nb++;
            if (!stall_o) begin
                done = 1;
                if (memop) begin
                    chk("res_wb",    32'(WB_o), 32'(e_wb));
                    chk("res_alu",   alu_o, e_alu);
                    chk("res_rd",    32'(rd_o), 32'(e_rd));
                    chk("res_rdata", rdata_o, e_rdata);
                end
            end
            @(posedge clk_i);
            @(negedge clk_i);
            cyc++;
        end
        if (memop) begin
            chk("stall_cycles", 32'(stall_cnt), 32'(tmo ? T + 1 : lat + 2));
            chk("req_cycles",   32'(req_cnt),   32'(tmo ? T : lat + 1));
            chk("nonbubble",    32'(nb),        32'(nb_exp));
            chk("post_wb",      32'(WB_o),      32'd0);
            chk("post_rd",      32'(rd_o),      32'd0);
            chk("post_alu",     alu_o,          e_alu);
            chk("post_rdata",   rdata_o,        e_rdata);
        end else begin
            chk("alu_stall", 32'(stall_cnt), 32'd0);
            chk("alu_wb",    32'(WB_o),      32'(wb));
            chk("alu_alu",   alu_o,          addr);
            chk("alu_rd",    32'(rd_o),      32'(rd));
            chk("alu_rdata", rdata_o,        32'd0);
        end
        if (tmo) m_err = 1'b1;
        chk("err", 32'(err_o), 32'(m_err));
        m_alu   = e_alu;
        m_rdata = e_rdata;
    endtask

    task automatic model_reset();
        m_alu = '0; m_rdata = '0; m_err = 1'b0;
        low_run = 0; have_req = 0; req_prev = 0;
    endtask

    initial begin
        rst_n_i = 1'b0;
        WB_i = '0; M_i = '0; addr_i = '0; data_i = '0; rd_i = '0;
        mem_ack_i = 1'b0; mem_rdata_i = '0;
        model_reset();
        @(negedge clk_i);
        @(negedge clk_i);
        chk_all_zero("reset");
        rst_n_i = 1'b1;

        run_instr(2'b10, 2'b00, 32'h1234, 32'h0, 5'd5, 0, 32'h0);
        run_instr(2'b11, 2'b10, 32'h100, 32'h0, 5'd7, 3, 32'hDEADBEEF);
        run_instr(2'b00, 2'b01, 32'h200, 32'hA5A5A5A5, 5'd0, 0, 32'h0);
        run_instr(2'b11, 2'b10, 32'h300, 32'h0, 5'd9, T - 1, 32'h0BADF00D);
        run_instr(2'b10, 2'b11, 32'h304, 32'h12345678, 5'd3, 1, 32'hFFFFFFFF);

        for (int i = 0; i < 40; i++) begin
            run_instr(2'($urandom), 2'($urandom), $urandom, $urandom, 5'($urandom),
                      int'($urandom_range(0, T - 2)), $urandom);
        end

        run_instr(2'b11, 2'b10, 32'h400, 32'h0, 5'd11, 99, 32'h0);
        run_instr(2'b10, 2'b00, 32'h55AA, 32'h0, 5'd12, 0, 32'h0);

        // Reset in the middle of an access
        WB_i = 2'b11; M_i = 2'b10; addr_i = 32'h500; rd_i = 5'd13; mem_ack_i = 1'b0;
        #1;
        @(posedge clk_i); @(negedge clk_i);
        @(posedge clk_i); @(negedge clk_i);
        chk("pre_rst_req", 32'(mem_req_o), 32'd1);
        rst_n_i = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        @(posedge clk_i); @(negedge clk_i);
        rst_n_i = 1'b1;
        model_reset();
        run_instr(2'b11, 2'b10, 32'h600, 32'h0, 5'd14, 2, 32'hCAFEF00D);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
